// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the streaming Hamming engine.
// Macro HAMMING_THRESH_EN (see hamming_stream) adds threshold matching.
package hamming_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic int dist_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of the XOR of two CHUNK-bit words.
// Result is $clog2(CHUNK+1) bits wide.
module popcount_chunk #(
    parameter int CHUNK = 32,
    localparam int PC_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [PC_W-1:0]  count
);

    logic [CHUNK-1:0] diff;

    assign diff = a ^ b;

    // Sum the differing bit positions.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + PC_W'(diff[i]);
        end
    end

endmodule

// File: rtl/hamming_stream.sv
// Streaming Hamming-distance engine: accumulates popcount(a^b) per beat.
// Define HAMMING_THRESH_EN to add the thresh input and match output.
module hamming_stream
    import hamming_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int CHUNK = 32,
    localparam int BEATS  = WIDTH / CHUNK,
    localparam int DIST_W = dist_w(WIDTH),
    localparam int CNT_W  = cnt_w(BEATS),
    localparam int PC_W   = $clog2(CHUNK + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHUNK-1:0]  a_word,
    input  logic [CHUNK-1:0]  b_word,
    output logic              dist_valid,
    input  logic              dist_ready,
`ifdef HAMMING_THRESH_EN
    input  logic [DIST_W-1:0] thresh,
    output logic              match,
`endif
    output logic [DIST_W-1:0] distance
);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DIST_W-1:0] acc;
    logic [DIST_W-1:0] sum;
    logic [PC_W-1:0]   pc;
    logic              accept;
    logic              last;

    popcount_chunk #(
        .CHUNK (CHUNK)
    ) u_pc (
        .a     (a_word),
        .b     (b_word),
        .count (pc)
    );

    assign in_ready   = (state == ACCUM);
    assign dist_valid = (state == DONE);
    assign accept     = in_valid & in_ready & ~flush;
    assign last       = (beat_cnt == CNT_W'(BEATS - 1));
    assign sum        = acc + DIST_W'(pc);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    // Next state; flush wins over beats and result handshake.
    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (accept && last) state_n = DONE;
            DONE:  if (dist_ready)     state_n = ACCUM;
            default:                   state_n = ACCUM;
        endcase
        if (flush) state_n = ACCUM;
    end

    // Beat counter and accumulator; both restart on flush or vector end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (flush) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else begin
                acc      <= sum;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Result register, loaded on the last beat and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            distance <= '0;
        end else if (accept && last) begin
            distance <= sum;
        end
    end

`ifdef HAMMING_THRESH_EN
    // Match flag registered alongside distance, thresh sampled on last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (accept && last) begin
            match <= (sum <= thresh);
        end
    end
`endif

endmodule

// File: tb/tb_hamming_stream.sv
// Directed self-checking bench for hamming_stream (WIDTH=256, CHUNK=32).
// Also exercises thresh/match when HAMMING_THRESH_EN is defined.
module tb_hamming_stream;

    localparam int WIDTH  = 256;
    localparam int CHUNK  = 32;
    localparam int DIST_W = 9;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CHUNK-1:0]  a_word;
    logic [CHUNK-1:0]  b_word;
    logic              dist_valid;
    logic              dist_ready;
    logic [DIST_W-1:0] distance;
`ifdef HAMMING_THRESH_EN
    logic [DIST_W-1:0] thresh;
    logic              match;
`endif

    int n_chk;
    int n_fail;

    hamming_stream #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_word     (a_word),
        .b_word     (b_word),
        .dist_valid (dist_valid),
        .dist_ready (dist_ready),
`ifdef HAMMING_THRESH_EN
        .thresh     (thresh),
        .match      (match),
`endif
        .distance   (distance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        a_word   = a;
        b_word   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        dist_ready = 1'b1;
        tick();
        dist_ready = 1'b0;
        chk("consume_valid", 32'(dist_valid), 0);
        chk("consume_ready", 32'(in_ready), 1);
    endtask

    logic [31:0] r;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        a_word     = '0;
        b_word     = '0;
        dist_ready = 1'b0;
`ifdef HAMMING_THRESH_EN
        thresh     = '0;
`endif
        #22;
        chk("rst_valid", 32'(dist_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_dist", 32'(distance), 0);
        rst_n = 1'b1;
        tick();

        // 1: all bits differ, back-to-back beats
        for (int i = 0; i < 7; i++) beat(32'h0, 32'hFFFF_FFFF);
        chk("t1_early", 32'(dist_valid), 0);
        beat(32'h0, 32'hFFFF_FFFF);
        chk("t1_valid", 32'(dist_valid), 1);
        chk("t1_dist", 32'(distance), 256);
        chk("t1_ready", 32'(in_ready), 0);
        consume();

        // 2: equal operands
`ifdef HAMMING_THRESH_EN
        thresh = 9'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            beat(r, r);
        end
        chk("t2_valid", 32'(dist_valid), 1);
        chk("t2_dist", 32'(distance), 0);
`ifdef HAMMING_THRESH_EN
        chk("t2_match", 32'(match), 1);
`endif
        consume();

        // 3: bit0 differs per chunk, gaps between beats
        for (int i = 0; i < 8; i++) begin
            beat(32'h1234_5678, 32'h1234_5679);
            if (i % 2 == 0) tick();
            if (i == 3) begin tick(); tick(); end
        end
        chk("t3_valid", 32'(dist_valid), 1);
        chk("t3_dist", 32'(distance), 8);
`ifdef HAMMING_THRESH_EN
        chk("t3_match", 32'(match), 0);
`endif

        // 4: consumer stalls; offered beats must be ignored
        in_valid = 1'b1;
        a_word   = 32'h0;
        b_word   = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_dist", 32'(distance), 8);
            chk("t4_hold_rdy", 32'(in_ready), 0);
        end
        chk("t4_hold_valid", 32'(dist_valid), 1);
        dist_ready = 1'b1;
        tick();
        dist_ready = 1'b0;
        in_valid   = 1'b0;
        chk("t4_released", 32'(dist_valid), 0);
`ifdef HAMMING_THRESH_EN
        thresh = 9'd8;
`endif
        for (int i = 0; i < 7; i++) beat(32'h0, 32'h1);
        chk("t4_early", 32'(dist_valid), 0);
        beat(32'h0, 32'h1);
        chk("t4_valid", 32'(dist_valid), 1);
        chk("t4_dist", 32'(distance), 8);
`ifdef HAMMING_THRESH_EN
        chk("t4_match", 32'(match), 1);
`endif
        consume();

        // 5: flush after three beats, with a beat offered that cycle
        for (int i = 0; i < 3; i++) beat(32'h0, 32'hFFFF_FFFF);
        flush    = 1'b1;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_valid", 32'(dist_valid), 0);
        for (int i = 0; i < 7; i++) beat(32'hFFFF_FFFF, 32'h0);
        chk("t5_early", 32'(dist_valid), 0);
        beat(32'hFFFF_FFFF, 32'h0);
        chk("t5_valid", 32'(dist_valid), 1);
        chk("t5_dist", 32'(distance), 256);

        // 5b: flush in DONE drops the result
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5b_valid", 32'(dist_valid), 0);
        chk("t5b_ready", 32'(in_ready), 1);

        // 6: async reset mid-vector, off the clock edge
        for (int i = 0; i < 4; i++) beat(32'h0, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(dist_valid), 0);
        chk("t6_rst_ready", 32'(in_ready), 1);
        chk("t6_rst_dist", 32'(distance), 0);
`ifdef HAMMING_THRESH_EN
        chk("t6_rst_match", 32'(match), 0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) beat(32'h0, 32'h0000_000F);
        chk("t6_early", 32'(dist_valid), 0);
        beat(32'h0, 32'h0000_000F);
        chk("t6_valid", 32'(dist_valid), 1);
        chk("t6_dist", 32'(distance), 32);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
